// File: rtl/patchembed_pkg.sv
// Shared types, default parameters and width helper for the patch-embedding
// controller and its window generator.
package patchembed_pkg;

    localparam int KERNELS_DEF = 64;
    localparam int PIXEL_DEF   = 224;
    localparam int SIZE_DEF    = 16;
    localparam int STRIDE_DEF  = 8;
    localparam int SUM_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WT,
        COMPUTE,
        STORE,
        DONE
    } pe_state_t;

    // Address width for n locations, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_window_gen.sv
// Window corner generator: raster-steps the top-left corner of the patch
// window by STRIDE, column first, then row.
module pe_window_gen
    import patchembed_pkg::*;
#(
    parameter int PIXEL  = PIXEL_DEF,
    parameter int SIZE   = SIZE_DEF,
    parameter int STRIDE = STRIDE_DEF,
    parameter int PW     = clog2w(PIXEL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [PW-1:0] win_row,
    output logic [PW-1:0] win_col
);

    localparam logic [PW:0] LIMIT = (PW+1)'(PIXEL - SIZE);
    localparam logic [PW:0] STEP  = (PW+1)'(STRIDE);

    logic [PW:0] col_step;
    logic [PW:0] row_step;

    assign col_step = {1'b0, win_col} + STEP;
    assign row_step = {1'b0, win_row} + STEP;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            win_row <= '0;
            win_col <= '0;
        end else if (advance) begin
            if (col_step > LIMIT) begin
                // NOTE: at the last window the corner holds rather than stepping past the image edge.
                if (row_step <= LIMIT) begin
                    win_row <= row_step[PW-1:0];
                    win_col <= '0;
                end
            end else begin
                win_col <= col_step[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/patchembed_ctrl.sv
// Patch-embedding sequencer: loads kernel weights, then for every window
// waits for the adder tree and writes one result per output channel.
module patchembed_ctrl
    import patchembed_pkg::*;
#(
    parameter int  KERNELS  = KERNELS_DEF,
    parameter int  PIXEL    = PIXEL_DEF,
    parameter int  SIZE     = SIZE_DEF,
    parameter int  STRIDE   = STRIDE_DEF,
    parameter int  SUM_LAT  = SUM_LAT_DEF,
    localparam int OUT_SIZE = (PIXEL - SIZE) / STRIDE + 1,
    localparam int NWIN     = OUT_SIZE * OUT_SIZE,
    localparam int KW       = clog2w(KERNELS),
    localparam int PW       = clog2w(PIXEL),
    localparam int IW       = clog2w(NWIN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [KW-1:0] wt_rd_addr,
    output logic          mac_load,
    output logic [PW-1:0] win_row,
    output logic [PW-1:0] win_col,
    output logic          sum_capture,
    output logic          out_wen,
    output logic [KW-1:0] out_ch,
    output logic [IW-1:0] out_idx
);

    localparam int            LW     = clog2w(SUM_LAT);
    localparam logic [KW-1:0] K_LAST = KW'(KERNELS - 1);
    localparam logic [IW-1:0] W_LAST = IW'(NWIN - 1);
    localparam logic [LW-1:0] L_LAST = LW'(SUM_LAT - 1);

    pe_state_t     state, next_state;
    logic [LW-1:0] lat_cnt, lat_next;
    logic          out_wen_q;
    logic          write;
    logic          win_clear;
    logic          win_adv;

    always_comb begin
        next_state = state;
        lat_next   = '0;
        win_clear  = 1'b0;
        win_adv    = 1'b0;
        write      = (state == STORE) && out_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD_WT;
                    win_clear  = 1'b1;
                end
            end
            LOAD_WT: begin
                if (wt_rd_addr == K_LAST) next_state = COMPUTE;
            end
            COMPUTE: begin
                if (lat_cnt == L_LAST) next_state = STORE;
                else                   lat_next   = lat_cnt + 1'b1;
            end
            STORE: begin
                if (write && out_ch == K_LAST) begin
                    if (out_idx == W_LAST) begin
                        next_state = DONE;
                    end else begin
                        next_state = COMPUTE;
                        win_adv    = 1'b1;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mac_load    <= 1'b0;
            sum_capture <= 1'b0;
            out_wen_q   <= 1'b0;
            lat_cnt     <= '0;
            wt_rd_addr  <= '0;
            out_ch      <= '0;
            out_idx     <= '0;
        end else begin
            state       <= next_state;
            busy        <= (next_state != IDLE);
            done        <= (next_state == DONE);
            mac_load    <= (next_state == LOAD_WT);
            out_wen_q   <= (next_state == STORE);
            sum_capture <= (next_state == COMPUTE) && (lat_next == L_LAST);
            lat_cnt     <= lat_next;

            if (state == IDLE && start) begin
                wt_rd_addr <= '0;
                out_ch     <= '0;
                out_idx    <= '0;
            end
            if (state == LOAD_WT && wt_rd_addr != K_LAST) wt_rd_addr <= wt_rd_addr + 1'b1;
            if (state == COMPUTE && next_state == STORE)  out_ch     <= '0;
            if (write && out_ch != K_LAST)                out_ch     <= out_ch + 1'b1;
            if (win_adv)                                  out_idx    <= out_idx + 1'b1;
        end
    end

    // NOTE: the synchronous reset only lands at the edge, so the write strobe is masked during the reset cycle itself.
    assign out_wen = out_wen_q & ~reset;

    pe_window_gen #(
        .PIXEL  (PIXEL),
        .SIZE   (SIZE),
        .STRIDE (STRIDE),
        .PW     (PW)
    ) u_window_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (win_clear),
        .advance (win_adv),
        .win_row (win_row),
        .win_col (win_col)
    );

endmodule

// File: tb/tb_patchembed_ctrl.sv
// Self-checking bench for patchembed_ctrl: a loop-nest reference of one run is
// walked cycle by cycle against the DUT under random backpressure and start noise.
module tb_patchembed_ctrl;

    localparam int K  = 4;
    localparam int P  = 32;
    localparam int S  = 16;
    localparam int ST = 8;
    localparam int SL = 2;
    localparam int OS = (P - S) / ST + 1;
    localparam int NW = OS * OS;
    localparam int KW = $clog2(K);
    localparam int PW = $clog2(P);
    localparam int IW = $clog2(NW);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, done, mac_load, sum_capture, out_wen;
    logic [KW-1:0] wt_rd_addr, out_ch;
    logic [PW-1:0] win_row, win_col;
    logic [IW-1:0] out_idx;

    patchembed_ctrl #(
        .KERNELS (K),
        .PIXEL   (P),
        .SIZE    (S),
        .STRIDE  (ST),
        .SUM_LAT (SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .wt_rd_addr  (wt_rd_addr),
        .mac_load    (mac_load),
        .win_row     (win_row),
        .win_col     (win_col),
        .sum_capture (sum_capture),
        .out_wen     (out_wen),
        .out_ch      (out_ch),
        .out_idx     (out_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus: start kick / start noise while busy, and out_ready pattern.
    int ready_mode   = 0;
    bit noise_en     = 1'b0;
    bit kick_req     = 1'b0;
    int stall_left   = 0;
    bit stalled_once = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (kick_req) begin
            start    = 1'b1;
            kick_req = 1'b0;
        end else begin
            start = noise_en && busy && ($urandom_range(0, 2) == 0);
        end
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (!stalled_once && out_wen && out_ch == 2) begin
                    out_ready    = 1'b0;
                    stall_left   = 2;
                    stalled_once = 1'b1;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    int writes_seen = 0;
    int done_seen   = 0;

    always @(negedge clk) begin
        if (out_wen && out_ready) writes_seen++;
        if (done) done_seen++;
    end

    task automatic check_reset_outputs(input string ph);
        check({ph, "_busy"}, busy, 0);
        check({ph, "_done"}, done, 0);
        check({ph, "_mac_load"}, mac_load, 0);
        check({ph, "_sum_capture"}, sum_capture, 0);
        check({ph, "_out_wen"}, out_wen, 0);
        check({ph, "_wt_rd_addr"}, wt_rd_addr, 0);
        check({ph, "_win_row"}, win_row, 0);
        check({ph, "_win_col"}, win_col, 0);
        check({ph, "_out_ch"}, out_ch, 0);
        check({ph, "_out_idx"}, out_idx, 0);
    endtask

    task automatic expect_flags(input string ph, input bit ml, input bit sc, input bit we, input bit dn);
        check({ph, "_busy"}, busy, 1);
        check({ph, "_mac_load"}, mac_load, ml);
        check({ph, "_sum_capture"}, sum_capture, sc);
        check({ph, "_out_wen"}, out_wen, we);
        check({ph, "_done"}, done, dn);
    endtask

    // Reference run: weight load, then per window SUM_LAT settle cycles and
    // one write per channel, stretched by whatever out_ready does.
    task automatic run_model(input int abort_idx, output int done_t, output bit aborted);
        int t;
        int stalls;
        int waited;
        int er, ec;
        bit ok;
        bit written;
        t       = 0;
        stalls  = 0;
        done_t  = -1;
        aborted = 1'b0;
        ok      = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = busy;
        end
        check("busy_rise", ok, 1);
        if (!ok) return;

        for (int k = 0; k < K; k++) begin
            expect_flags("load", 1, 0, 0, 0);
            check("load_wt_rd_addr", wt_rd_addr, k);
            @(negedge clk);
            t++;
        end

        for (int w = 0; w < NW; w++) begin
            er = (w / OS) * ST;
            ec = (w % OS) * ST;
            for (int c = 0; c < SL; c++) begin
                expect_flags("compute", 0, (c == SL - 1), 0, 0);
                check("compute_win_row", win_row, er);
                check("compute_win_col", win_col, ec);
                check("compute_out_idx", out_idx, w);
                @(negedge clk);
                t++;
            end
            for (int ch = 0; ch < K; ch++) begin
                written = 1'b0;
                waited  = 0;
                while (!written) begin
                    expect_flags("store", 0, 0, 1, 0);
                    check("store_out_ch", out_ch, ch);
                    check("store_out_idx", out_idx, w);
                    check("store_win_row", win_row, er);
                    check("store_win_col", win_col, ec);
                    if (w == abort_idx && ch == 1) begin
                        aborted = 1'b1;
                        return;
                    end
                    written = out_ready;
                    if (!written) begin
                        stalls++;
                        waited++;
                        if (waited > 64) begin
                            check("stall_bound", waited, 0);
                            return;
                        end
                    end
                    @(negedge clk);
                    t++;
                end
            end
        end

        expect_flags("done", 0, 0, 0, 1);
        check("done_out_idx", out_idx, NW - 1);
        check("done_out_ch", out_ch, K - 1);
        check("done_win_row", win_row, ((NW - 1) / OS) * ST);
        check("done_win_col", win_col, ((NW - 1) % OS) * ST);
        check("run_length", t, K + NW * (SL + K) + stalls);
        done_t = t;
        @(negedge clk);
        check("after_done_busy", busy, 0);
        check("after_done_done", done, 0);
    endtask

    int  dt;
    bit  ab;
    int  w0, d0;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);

        // Clean run: done on run cycle 59 counting LOAD_WT entry as cycle 1
        ready_mode = 0;
        noise_en   = 1'b0;
        w0 = writes_seen; d0 = done_seen;
        kick_req = 1'b1;
        run_model(-1, dt, ab);
        @(posedge clk);
        check("clean_done_cycle", dt + 1, 59);
        check("clean_writes", writes_seen - w0, 36);
        check("clean_done_pulses", done_seen - d0, 1);

        // Three-cycle stall at out_ch=2 stretches the run by three cycles
        ready_mode   = 2;
        stalled_once = 1'b0;
        w0 = writes_seen; d0 = done_seen;
        kick_req = 1'b1;
        run_model(-1, dt, ab);
        @(posedge clk);
        check("stall_done_cycle", dt + 1, 62);
        check("stall_writes", writes_seen - w0, 36);
        check("stall_done_pulses", done_seen - d0, 1);

        // Random backpressure with start asserted at random while busy
        ready_mode = 1;
        noise_en   = 1'b1;
        w0 = writes_seen; d0 = done_seen;
        kick_req = 1'b1;
        run_model(-1, dt, ab);
        @(posedge clk);
        check("random_writes", writes_seen - w0, 36);
        check("random_done_pulses", done_seen - d0, 1);

        // Reset during STORE at out_idx=5
        d0 = done_seen;
        kick_req = 1'b1;
        run_model(5, dt, ab);
        check("abort_reached", ab, 1);
        reset = 1'b1;
        #1;
        check("abort_no_write_in_reset_cycle", out_wen, 0);
        @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b0;
        check("abort_no_done", done_seen - d0, 0);
        @(posedge clk);

        // Full pass after the abort
        w0 = writes_seen; d0 = done_seen;
        kick_req = 1'b1;
        run_model(-1, dt, ab);
        @(posedge clk);
        check("rerun_writes", writes_seen - w0, 36);
        check("rerun_done_pulses", done_seen - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
